// File: rtl/fetch_ras.sv
// Return-address stack for the fetch stage: pushes link addresses on calls,
// pops on returns, and exposes tos/count for branch-recovery checkpointing.
module fetch_ras #(
  parameter int unsigned LG_DEPTH = 3,
  parameter int unsigned XLEN     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [3:0]          fetch_pd,
  input  logic [XLEN-1:0]     fetch_pc,
  input  logic                restore_valid,
  input  logic [LG_DEPTH-1:0] restore_tos,
  input  logic [LG_DEPTH:0]   restore_count,
  output logic [XLEN-1:0]     ret_pc,
  output logic                ret_valid,
  output logic [LG_DEPTH-1:0] tos,
  output logic [LG_DEPTH:0]   count
);

  localparam int unsigned       DEPTH = 2 ** LG_DEPTH;
  localparam logic [LG_DEPTH:0] FULL  = (LG_DEPTH+1)'(DEPTH);

  typedef enum logic [3:0] {
    PD_NONE  = 4'd0,
    PD_COND  = 4'd1,
    PD_RET   = 4'd2,
    PD_J     = 4'd3,
    PD_JR    = 4'd4,
    PD_JAL   = 4'd5,
    PD_JALR  = 4'd6
  } pd_e;

  logic [XLEN-1:0]     entry [DEPTH];
  logic                push;
  logic                pop;
  logic [LG_DEPTH-1:0] tos_inc;
  logic [LG_DEPTH-1:0] tos_dec;

  always_comb begin
    push    = fetch_valid && (fetch_pd == PD_JAL || fetch_pd == PD_JALR);
    pop     = fetch_valid && (fetch_pd == PD_RET) && (count != '0);
    tos_inc = tos + LG_DEPTH'(1);
    tos_dec = tos - LG_DEPTH'(1);
  end

  // Reset beats restore, restore beats any same-cycle push/pop.
  // A push into a full stack wraps and silently overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos   <= '0;
      count <= '0;
      entry <= '{default: '0};
    end else if (restore_valid) begin
      tos   <= restore_tos;
      count <= restore_count;
    end else if (push) begin
      entry[tos_inc] <= fetch_pc + XLEN'(4);
      tos            <= tos_inc;
      if (count != FULL) count <= count + (LG_DEPTH+1)'(1);
    end else if (pop) begin
      tos   <= tos_dec;
      count <= count - (LG_DEPTH+1)'(1);
    end
  end

  always_comb begin
    ret_valid = (count != '0);
    ret_pc    = ret_valid ? entry[tos] : '0;
  end

endmodule

// File: tb/tb_fetch_ras.sv
// Directed + random bench for fetch_ras against an array/arithmetic stack model.
module tb_fetch_ras;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, restore_valid;
  logic [3:0]  fetch_pd;
  logic [63:0] fetch_pc;
  logic [2:0]  restore_tos;
  logic [3:0]  restore_count;
  logic [63:0] ret_pc;
  logic        ret_valid;
  logic [2:0]  tos;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_ent [8];
  int          m_tos, m_cnt;

  fetch_ras #(.LG_DEPTH(3), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pd(fetch_pd),
    .fetch_pc(fetch_pc), .restore_valid(restore_valid), .restore_tos(restore_tos),
    .restore_count(restore_count), .ret_pc(ret_pc), .ret_valid(ret_valid),
    .tos(tos), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stack behaviour as stated: circular 8-entry buffer, saturating occupancy.
  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 8; i++) m_ent[i] = '0;
      m_tos = 0;
      m_cnt = 0;
    end else if (restore_valid) begin
      m_tos = int'(restore_tos);
      m_cnt = int'(restore_count);
    end else if (fetch_valid && (fetch_pd == 4'd5 || fetch_pd == 4'd6)) begin
      m_tos = (m_tos + 1) % 8;
      m_ent[m_tos] = fetch_pc + 64'd4;
      if (m_cnt < 8) m_cnt = m_cnt + 1;
    end else if (fetch_valid && fetch_pd == 4'd2 && m_cnt > 0) begin
      m_tos = (m_tos + 7) % 8;
      m_cnt = m_cnt - 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ret_pc"},    ret_pc, (m_cnt != 0) ? m_ent[m_tos] : 64'd0);
    chk({tag, ".ret_valid"}, {63'd0, ret_valid}, (m_cnt != 0) ? 64'd1 : 64'd0);
    chk({tag, ".tos"},       {61'd0, tos}, 64'(m_tos));
    chk({tag, ".count"},     {60'd0, count}, 64'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic op(input string tag, input logic v, input logic [3:0] pd, input logic [63:0] pc);
    reset = 1'b0; restore_valid = 1'b0;
    fetch_valid = v; fetch_pd = pd; fetch_pc = pc;
    tick(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; restore_valid = 1'b0; fetch_valid = 1'b0;
    tick("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_pd = '0; fetch_pc = '0;
    restore_valid = 1'b0; restore_tos = '0; restore_count = '0;
    for (int i = 0; i < 8; i++) m_ent[i] = '0;
    m_tos = 0; m_cnt = 0;

    do_reset();
    chk("rst_ret_pc", ret_pc, 64'd0);
    chk("rst_ret_valid", {63'd0, ret_valid}, 64'd0);
    chk("rst_tos", {61'd0, tos}, 64'd0);
    chk("rst_count", {60'd0, count}, 64'd0);
    op("idle", 1'b0, 4'd0, 64'h0);
    op("pd1", 1'b1, 4'd1, 64'h500);
    op("pd3", 1'b1, 4'd3, 64'h504);
    op("pd4", 1'b1, 4'd4, 64'h508);
    chk("nochange_count", {60'd0, count}, 64'd0);

    op("call", 1'b1, 4'd5, 64'h1000);
    chk("call_ret_pc", ret_pc, 64'h1004);
    chk("call_tos", {61'd0, tos}, 64'd1);
    chk("call_count", {60'd0, count}, 64'd1);
    op("ret", 1'b1, 4'd2, 64'h1100);
    chk("ret_ret_valid", {63'd0, ret_valid}, 64'd0);
    chk("ret_ret_pc", ret_pc, 64'd0);

    op("nest0", 1'b1, 4'd6, 64'h2000);
    op("nest1", 1'b1, 4'd5, 64'h3000);
    op("nest2", 1'b1, 4'd5, 64'h4000);
    chk("nest_top", ret_pc, 64'h4004);
    op("npop0", 1'b1, 4'd2, 64'h0);
    chk("npop0_pc", ret_pc, 64'h3004);
    op("npop1", 1'b1, 4'd2, 64'h0);
    chk("npop1_pc", ret_pc, 64'h2004);
    op("npop2", 1'b1, 4'd2, 64'h0);

    for (int i = 1; i <= 9; i++) op("ovf_push", 1'b1, 4'd5, 64'(i) * 64'h100);
    chk("ovf_count", {60'd0, count}, 64'd8);
    chk("ovf_top", ret_pc, 64'h904);
    for (int i = 0; i < 7; i++) begin
      op("ovf_pop", 1'b1, 4'd2, 64'h0);
      chk("ovf_pop_pc", ret_pc, 64'h904 - 64'(i + 1) * 64'h100);
    end
    op("ovf_pop8", 1'b1, 4'd2, 64'h0);
    chk("ovf_empty", {60'd0, count}, 64'd0);
    op("ovf_pop9", 1'b1, 4'd2, 64'h0);
    op("underflow", 1'b1, 4'd2, 64'h0);
    op("gated", 1'b0, 4'd5, 64'h6000);
    chk("gated_valid", {63'd0, ret_valid}, 64'd0);
    op("wrap", 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc", ret_pc, 64'd0);
    chk("wrap_valid", {63'd0, ret_valid}, 64'd1);

    do_reset();
    op("rs_push0", 1'b1, 4'd5, 64'h1000);
    op("rs_push1", 1'b1, 4'd5, 64'h5000);
    fetch_valid = 1'b1; fetch_pd = 4'd5; fetch_pc = 64'h7000;
    restore_valid = 1'b1; restore_tos = 3'd1; restore_count = 4'd1;
    tick("restore");
    chk("restore_pc", ret_pc, 64'h1004);
    chk("restore_tos", {61'd0, tos}, 64'd1);
    reset = 1'b1; restore_tos = 3'd3; restore_count = 4'd5;
    tick("rst_vs_restore");
    chk("rst_wins_count", {60'd0, count}, 64'd0);

    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      restore_valid = ($urandom_range(0, 9) == 0);
      restore_tos   = 3'($urandom_range(0, 7));
      restore_count = 4'($urandom_range(0, 8));
      fetch_valid   = ($urandom_range(0, 4) != 0);
      fetch_pd      = 4'($urandom_range(0, 7));
      fetch_pc      = {$urandom, $urandom};
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ras.md
# fetch_ras

Return-address stack that consumes the 4-bit control-flow class produced by instruction predecode and the PC of each fetched instruction. It pushes link addresses on calls, pops on returns, and presents a predicted return target to the fetch next-PC logic. It sits in the fetch stage directly downstream of predecode. It also exports its pointer state so the branch-recovery logic can checkpoint it and repair it after a misprediction.

## Interface
Parameters:
- LG_DEPTH, 3, log2 of stack depth (DEPTH = 2^LG_DEPTH = 8)
- XLEN, 64, address width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch_pd/fetch_pc describe a real fetched instruction this cycle
- fetch_pd  in  4  control-flow class: 0 none, 1 cond branch, 2 return, 3 j, 4 jr, 5 jal-link, 6 jalr
- fetch_pc  in  XLEN  PC of the instruction
- restore_valid  in  1  load checkpointed pointer state
- restore_tos  in  LG_DEPTH  checkpointed top-of-stack index
- restore_count  in  LG_DEPTH+1  checkpointed occupancy (0..DEPTH)
- ret_pc  out  XLEN  predicted return target; top entry, forced to 0 when ret_valid=0
- ret_valid  out  1  stack non-empty (count != 0)
- tos  out  LG_DEPTH  current top-of-stack index, for checkpointing
- count  out  LG_DEPTH+1  current occupancy, for checkpointing

## Operation
- State: DEPTH x XLEN entry array, tos register, count register (0..DEPTH).
- Push event: fetch_valid && (fetch_pd==5 || fetch_pd==6). Pop event: fetch_valid && fetch_pd==2. All other pd values (0,1,3,4) and fetch_valid=0 leave the state unchanged.
- Push: entry[tos+1 mod DEPTH] <= fetch_pc + 4 (XLEN-bit add, wraps modulo 2^XLEN); tos <= tos+1 mod DEPTH; count <= min(count+1, DEPTH).
- Full push (count==DEPTH): the pointer wraps and overwrites the oldest entry. Count stays DEPTH. No error is flagged.
- Pop with count>0: tos <= tos-1 mod DEPTH; count <= count-1. The entry is not cleared.
- Pop with count==0 (underflow): no state change; ret_valid stays 0.
- ret_pc/ret_valid are a combinational read of registered state (entry[tos], count). During a pop cycle, fetch uses the pre-pop ret_pc as the return target.
- Restore: when restore_valid=1, tos <= restore_tos and count <= restore_count. The entry array is untouched. Any fetch push/pop in the same cycle is dropped, so restore has priority.
- restore_count > DEPTH is illegal input; the bench must not drive it.
- Reset has priority over restore and fetch.
  - Reset sets tos=0, count=0 and clears every entry to 0.
  - After reset: ret_pc=0, ret_valid=0, tos=0, count=0.
  - Reset asserted mid-sequence discards all pending contents at that edge.

## Timing
- Single-cycle update: an event sampled at edge N is visible on ret_pc/ret_valid/tos/count after edge N (cycle N+1).
- No stalls and no backpressure; one event per cycle maximum.
- Push followed by pop in back-to-back cycles: the pop returns the just-pushed address.
- Outputs are combinational from registers only. There is no input-to-output combinational path.
- Reset, restore, push and pop all take effect at the same edge as their sampling.

## Test plan
- Reset, then idle: ret_valid=0, ret_pc=0, tos=0, count=0. Then pd=1,3,4 with fetch_valid=1: no change.
- Call/return pair: push pd=5 at pc 0x1000 -> next cycle ret_pc=0x1004, ret_valid=1, count=1, tos=1. Then pd=2 -> count=0, ret_valid=0, ret_pc=0.
- Nested calls, strict LIFO order:
  - Pushes: pd=6 at 0x2000, pd=5 at 0x3000, pd=5 at 0x4000.
  - Three pops return 0x4004, 0x3004, 0x2004 in that order.
- Overflow:
  - Push 9 calls at pcs 0x100, 0x200, ... 0x900. Count saturates at 8; top ret_pc=0x904.
  - Eight pops yield 0x904 down to 0x204; the ninth pop sees count=0 and changes nothing.
- Underflow, fetch_valid gating and wrap:
  - pd=2 on an empty stack: no change.
  - pd=5 with fetch_valid=0: no change.
  - Push at pc 0xFFFF_FFFF_FFFF_FFFC gives ret_pc=0.
- Restore and simultaneity:
  - Push 0x1000, record tos/count (1,1), push 0x5000.
  - Assert restore_valid with (1,1) together with a pd=5 push at 0x7000: next cycle tos=1, count=1, ret_pc=0x1004, and the push is dropped.
  - Assert reset together with restore: reset wins.
